// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: load/store controller in front of a word-wide, single-port
// data RAM with a one-cycle registered read and no byte enables.
// Sub-word stores become a read-modify-write sequence; loads are lane-selected
// and sign- or zero-extended. Exactly one response strobe per accepted request.
module data_mem_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH+1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RMW  = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t state_reg, state_next;

    // Request fields held for the LOAD / RMW cycle
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [1:0]            lane_reg;
    logic [1:0]            size_reg;
    logic                  unsigned_reg;
    logic [15:0]           wdata_reg;

    // Registered response
    logic                  rsp_valid_reg;
    logic [DATA_WIDTH-1:0] rsp_rdata_reg;
    logic                  rsp_err_reg;

    logic                  accept;
    logic                  req_err;
    logic                  word_store;
    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] merge_data;
    logic [3:0]            byte_sel;

    assign accept = req_valid & req_ready;

    // Decode misalignment / reserved size of the incoming request
    always_comb begin
        req_err = 1'b0;
        case (req_size)
            SIZE_BYTE: req_err = 1'b0;
            SIZE_HALF: req_err = req_addr[0];
            SIZE_WORD: req_err = (req_addr[1:0] != 2'b00);
            default:   req_err = 1'b1;
        endcase
    end

    // Full-word stores go straight to the RAM in the accept cycle
    assign word_store = req_we & (req_size == SIZE_WORD) & ~req_err;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    if (req_err || word_store) begin
                        state_next = S_RESP;
                    end else if (req_we) begin
                        state_next = S_RMW;
                    end else begin
                        state_next = S_LOAD;
                    end
                end
            end
            S_LOAD:  state_next = S_IDLE;
            S_RMW:   state_next = S_RESP;
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs: handshake and RAM port; write enable is killed while in reset
    always_comb begin
        req_ready   = 1'b0;
        ram_we      = 1'b0;
        ram_address = addr_reg;
        ram_data    = merge_data;
        case (state_reg)
            S_IDLE: begin
                req_ready   = 1'b1;
                ram_address = req_addr[ADDR_WIDTH+1:2];
                ram_data    = req_wdata;
                ram_we      = req_valid & word_store;
            end
            S_RMW:   ram_we = 1'b1;
            default: ram_we = 1'b0;
        endcase
        ram_we = ram_we & reset_n;
    end

    // Capture request fields at accept
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_reg     <= '0;
            lane_reg     <= '0;
            size_reg     <= '0;
            unsigned_reg <= 1'b0;
            wdata_reg    <= '0;
        end else if (accept) begin
            addr_reg     <= req_addr[ADDR_WIDTH+1:2];
            lane_reg     <= req_addr[1:0];
            size_reg     <= req_size;
            unsigned_reg <= req_unsigned;
            wdata_reg    <= req_wdata[15:0];
        end
    end

    // Per-lane merge for sub-word stores: replaced lanes take held store data
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign byte_sel[gi] = (size_reg == SIZE_BYTE) ? (lane_reg == 2'(gi))
                                                          : (lane_reg[1] == 1'(gi / 2));
            assign merge_data[8*gi +: 8] =
                !byte_sel[gi]            ? ram_q[8*gi +: 8] :
                (size_reg == SIZE_HALF)  ? wdata_reg[8*(gi % 2) +: 8] :
                                           wdata_reg[7:0];
        end
    endgenerate

    // Lane select and sign/zero extension of load data
    always_comb begin
        logic [7:0]  lane_byte;
        logic [15:0] lane_half;
        lane_byte = ram_q[7:0];
        case (lane_reg)
            2'd0: lane_byte = ram_q[7:0];
            2'd1: lane_byte = ram_q[15:8];
            2'd2: lane_byte = ram_q[23:16];
            2'd3: lane_byte = ram_q[31:24];
            default: lane_byte = ram_q[7:0];
        endcase
        lane_half = lane_reg[1] ? ram_q[31:16] : ram_q[15:0];
        case (size_reg)
            SIZE_BYTE: load_data = {{24{lane_byte[7] & ~unsigned_reg}}, lane_byte};
            SIZE_HALF: load_data = {{16{lane_half[15] & ~unsigned_reg}}, lane_half};
            default:   load_data = ram_q;
        endcase
    end

    // Response register: one-cycle strobe, data/err held until next response
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
        end else begin
            rsp_valid_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (accept && (req_err || word_store)) begin
                        rsp_valid_reg <= 1'b1;
                        rsp_err_reg   <= req_err;
                        rsp_rdata_reg <= '0;
                    end
                end
                S_LOAD: begin
                    rsp_valid_reg <= 1'b1;
                    rsp_err_reg   <= 1'b0;
                    rsp_rdata_reg <= load_data;
                end
                S_RMW: begin
                    rsp_valid_reg <= 1'b1;
                    rsp_err_reg   <= 1'b0;
                    rsp_rdata_reg <= '0;
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: a behavioural RAM with registered read,
// a response scoreboard, and latency / RAM-port checks per request.
module tb_data_mem_ctrl;

    localparam int DW = 32;
    localparam int AW = 12;

    logic          clk;
    logic          reset_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [AW+1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          ram_we;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data;
    logic [DW-1:0] ram_q;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected response entries: {err, rdata}
    logic [DW:0] sb_q[$];

    logic [DW-1:0] mem [0:(1<<AW)-1];

    data_mem_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .ram_we       (ram_we),
        .ram_address  (ram_address),
        .ram_data     (ram_data),
        .ram_q        (ram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: one-cycle registered read, read-before-write
    always @(posedge clk) begin
        if (ram_we) mem[ram_address] <= ram_data;
        ram_q <= mem[ram_address];
    end

    task automatic check(input string tag, input logic [DW:0] got, input logic [DW:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard: every response strobe pops and compares one expected entry
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_rsp", 1'b1, 1'b0);
            end else begin
                logic [DW:0] e;
                e = sb_q.pop_front();
                check("rsp_err", rsp_err, e[DW]);
                check("rsp_rdata", rsp_rdata, e[DW-1:0]);
            end
        end
    end

    // One request: drive, check RAM port in accept cycle, measure latency
    task automatic do_req(input string name, input logic we, input logic [1:0] size,
                          input logic uns, input logic [AW+1:0] addr, input logic [DW-1:0] wdata,
                          input logic [DW-1:0] exp_rdata, input logic exp_err, input int exp_lat,
                          input logic exp_we_acc, input logic chk_rmw, input logic [DW-1:0] exp_rmw);
        int lat;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(negedge clk);
        check({name, "_ready"}, req_ready, 1'b1);
        check({name, "_we_acc"}, ram_we, exp_we_acc);
        check({name, "_addr"}, ram_address, addr[AW+1:2]);
        if (exp_we_acc) check({name, "_wdata"}, ram_data, wdata);
        sb_q.push_back({exp_err, exp_rdata});
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1 && chk_rmw) begin
                check({name, "_rmw_we"}, ram_we, 1'b1);
                check({name, "_rmw_data"}, ram_data, exp_rmw);
            end
            if (exp_err) check({name, "_no_we"}, ram_we, 1'b0);
        end while (rsp_valid !== 1'b1 && lat < 9);
        check({name, "_latency"}, lat, exp_lat);
        @(negedge clk);
        check({name, "_pulse"}, rsp_valid, 1'b0);
        $display("txn %s: we=%0b size=%0d addr=%h wdata=%h -> rdata=%h err=%0b lat=%0d",
                 name, we, size, addr, wdata, rsp_rdata, rsp_err, lat);
    endtask

    initial begin
        reset_n = 1'b0;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 14'h010; req_wdata = 32'h1111_1111;
        #1;
        check("reset_we_forced", ram_we, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_rsp_rdata", rsp_rdata, 32'h0);
        check("reset_rsp_err", rsp_err, 1'b0);
        req_valid = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        check("reset_ready", req_ready, 1'b1);

        //      name      we    size   uns   addr     wdata          exp_rdata      err  lat wacc rmw  exp_rmw
        do_req("sw",      1'b1, 2'b10, 1'b0, 14'h010, 32'hDEADBEEF, 32'h0,        1'b0, 1, 1'b1, 1'b0, 32'h0);
        do_req("lw",      1'b0, 2'b10, 1'b0, 14'h010, 32'h0,        32'hDEADBEEF, 1'b0, 2, 1'b0, 1'b0, 32'h0);
        do_req("sb",      1'b1, 2'b00, 1'b0, 14'h012, 32'hFFFFFF55, 32'h0,        1'b0, 2, 1'b0, 1'b1, 32'hDE55BEEF);
        do_req("lw2",     1'b0, 2'b10, 1'b0, 14'h010, 32'h0,        32'hDE55BEEF, 1'b0, 2, 1'b0, 1'b0, 32'h0);
        do_req("lb_s",    1'b0, 2'b00, 1'b0, 14'h013, 32'h0,        32'hFFFFFFDE, 1'b0, 2, 1'b0, 1'b0, 32'h0);
        do_req("lbu",     1'b0, 2'b00, 1'b1, 14'h013, 32'h0,        32'h000000DE, 1'b0, 2, 1'b0, 1'b0, 32'h0);
        do_req("lh_s",    1'b0, 2'b01, 1'b0, 14'h010, 32'h0,        32'hFFFFBEEF, 1'b0, 2, 1'b0, 1'b0, 32'h0);
        do_req("lhu_hi",  1'b0, 2'b01, 1'b1, 14'h012, 32'h0,        32'h0000DE55, 1'b0, 2, 1'b0, 1'b0, 32'h0);
        do_req("lb_pos",  1'b0, 2'b00, 1'b0, 14'h012, 32'h0,        32'h00000055, 1'b0, 2, 1'b0, 1'b0, 32'h0);
        do_req("err_lh",  1'b0, 2'b01, 1'b0, 14'h011, 32'h0,        32'h0,        1'b1, 1, 1'b0, 1'b0, 32'h0);
        do_req("err_sw",  1'b1, 2'b10, 1'b0, 14'h012, 32'h12345678, 32'h0,        1'b1, 1, 1'b0, 1'b0, 32'h0);
        do_req("err_sz",  1'b1, 2'b11, 1'b0, 14'h010, 32'h12345678, 32'h0,        1'b1, 1, 1'b0, 1'b0, 32'h0);
        do_req("sh",      1'b1, 2'b01, 1'b0, 14'h010, 32'h9999A5A5, 32'h0,        1'b0, 2, 1'b0, 1'b1, 32'hDE55A5A5);
        do_req("sb_l0",   1'b1, 2'b00, 1'b0, 14'h013, 32'h000000C3, 32'h0,        1'b0, 2, 1'b0, 1'b1, 32'hC355A5A5);
        do_req("lw3",     1'b0, 2'b10, 1'b0, 14'h010, 32'h0,        32'hC355A5A5, 1'b0, 2, 1'b0, 1'b0, 32'h0);

        // Reset asserted in the RMW cycle of a byte store: no write, no response
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 14'h011; req_wdata = 32'h00000077;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("abort_rmw_we_before", ram_we, 1'b1);
        reset_n = 1'b0;
        #1;
        check("abort_we_forced", ram_we, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_rsp", rsp_valid, 1'b0);
        end
        $display("txn abort: byte store to 014'h011 cut off by reset");
        do_req("lw_post", 1'b0, 2'b10, 1'b0, 14'h010, 32'h0,        32'hC355A5A5, 1'b0, 2, 1'b0, 1'b0, 32'h0);

        check("sb_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Load/store controller directly upstream of the data RAM (32-bit word-wide, 1-cycle registered read, no byte enables).
- Accepts byte-addressed CPU load/store requests with byte, halfword and word sizes.
- Implements sub-word stores as read-modify-write sequences.
- Sign- or zero-extends loaded lanes and returns one response per request.

Parameters:
- DATA_WIDTH, 32, RAM word width; fixed at 32 for lane logic.
- ADDR_WIDTH, 12, RAM word-address width; CPU byte address is ADDR_WIDTH+2 bits.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_addr  in  ADDR_WIDTH+2  byte address
- req_wdata  in  DATA_WIDTH  store data, right-justified
- rsp_valid  out  1  one-cycle response strobe
- rsp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned or reserved-size request
- ram_we  out  1  to RAM write enable
- ram_address  out  ADDR_WIDTH  to RAM address (word)
- ram_data  out  DATA_WIDTH  to RAM write data
- ram_q  in  DATA_WIDTH  from RAM, valid the cycle after the address was presented

Behaviour:
- Reset (async, reset_n=0): state IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, held address/data/size cleared. ram_we is forced to 0 combinationally while reset_n=0.
- Accept occurs on a rising edge with req_valid & req_ready. Request fields are captured into hold registers.
- Word index is req_addr[ADDR_WIDTH+1:2]; lane is req_addr[1:0]; little-endian (lane 0 = bits 7:0).
- Alignment error: halfword with addr[0]=1, word with addr[1:0]!=0, or size 11.
- RAM address mux: in IDLE, ram_address = word index of req_addr (combinational); in other states it is the held word index.
- States:
  - IDLE: accept.
    - Error request: no RAM write; go RESP with err=1.
    - Word store: ram_we=1, ram_data=req_wdata in the accept cycle; go RESP.
    - Sub-word store: ram_we=0; go RMW.
    - Load: ram_we=0; go LOAD.
  - LOAD: ram_q is valid. Select the lane, extend, register into rsp_rdata, pulse rsp_valid; go IDLE.
  - RMW: ram_q is valid. Drive ram_we=1 and ram_data = ram_q with the addressed byte or halfword replaced by held wdata[7:0] or [15:0]; go RESP.
  - RESP: rsp_valid=1 for this cycle (registered out of the previous state); go IDLE. rsp_rdata=0 for stores and errors.
- Latency from accept edge to rsp_valid high:
  - word store: 1 cycle
  - error: 1 cycle
  - load: 2 cycles
  - sub-word store: 2 cycles
- req_ready=0 in LOAD/RMW/RESP. A request held on req_valid is accepted in the first IDLE cycle after the response.
- Load extension:
  - Byte: bits 31:8 are all copies of bit 7 (signed) or 0 (unsigned).
  - Halfword: bits 31:16 are all copies of bit 15 (signed) or 0 (unsigned).
  - Word: passed unmodified.
- rsp_valid is high for exactly 1 cycle per accepted request. rsp_rdata and rsp_err hold their value until the next response.
- Reset during LOAD or RMW aborts the operation: no RAM write and no response. Requests in flight are lost.
- No internal forwarding is needed; the RAM write completes before the next accept.

Test Plan:
- Reset then word store of 0xDEADBEEF to byte addr 0x010: ram_we high in the accept cycle, ram_address=4; rsp_valid 1 cycle later, rsp_err=0, rsp_rdata=0.
- Word load from addr 0x010 after the above store: rsp_valid 2 cycles after accept, rsp_rdata=0xDEADBEEF.
- Byte store 0x55 to addr 0x012 after the above store, then word load of 0x010: RMW writes 0xDE55BEEF at cycle +1; load returns 0xDE55BEEF.
- Byte load of addr 0x013 (0xDE): signed returns 0xFFFFFFDE, unsigned returns 0x000000DE. Halfword load of 0x010 signed returns 0xFFFFBEEF.
- Misaligned halfword load at 0x011, word store at 0x012, and size=11: rsp_err=1 one cycle after accept, rsp_rdata=0, ram_we never asserted.
- Assert reset_n low in the RMW cycle of a byte store: ram_we=0 immediately, no rsp_valid, and a subsequent word load shows the RAM word unchanged.
